// File: rtl/wb_initiator.sv
// Wishbone B4 pipelined single-transaction initiator with retry and timeout.
// Ports: cmd_* request in, rsp_* response out, wb_* bus master side.
module wb_initiator #(
    parameter int AW        = 32,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [31:0]   cmd_dat_i,
    input  logic [3:0]    cmd_sel_i,
    output logic          rsp_valid_o,
    output logic [31:0]   rsp_dat_o,
    output logic [1:0]    rsp_status_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-3:0] wb_adr_o,
    output logic [3:0]    wb_sel_o,
    output logic [31:0]   wb_dat_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    input  logic          wb_stall_i,
    input  logic [31:0]   wb_dat_i
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, BACKOFF, RSP
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  MR      = 4'(MAX_RETRY);

    state_t        state_q;
    logic          cyc_q, stb_q, we_q, rdy_q;
    logic [AW-3:0] adr_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_dat_q;
    logic [1:0]    rsp_status_q;
    logic [15:0]   tmo_q;
    logic [3:0]    retry_q;

    // Byte offset bits are not part of the word address.
    logic unused_adr;
    assign unused_adr = ^cmd_adr_i[1:0];

    // A termination counts once the request is accepted (or in that cycle).
    logic live, t_err, t_ack, t_rty, expired;
    assign live    = (state_q == WAIT) ||
                     (state_q == REQ && !wb_stall_i);
    assign t_err   = live && wb_err_i;
    assign t_ack   = live && wb_ack_i && !wb_err_i;
    assign t_rty   = live && wb_rty_i && !wb_err_i && !wb_ack_i;
    assign expired = (tmo_q == TO_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            rdy_q        <= 1'b1;
            adr_q        <= '0;
            sel_q        <= '0;
            dat_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= 2'b00;
            tmo_q        <= '0;
            retry_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        we_q    <= cmd_we_i;
                        adr_q   <= cmd_adr_i[AW-1:2];
                        sel_q   <= cmd_sel_i;
                        dat_q   <= cmd_dat_i;
                        retry_q <= '0;
                        tmo_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        rdy_q   <= 1'b0;
                        state_q <= REQ;
                    end
                end
                REQ, WAIT: begin
                    tmo_q <= tmo_q + 16'd1;
                    if (state_q == REQ && !wb_stall_i) begin
                        stb_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                    // Timeout is checked last so a same-cycle
                    // termination wins over it.
                    priority case (1'b1)
                        t_err: begin
                            cyc_q        <= 1'b0;
                            stb_q        <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            rsp_dat_q    <= '0;
                            rsp_status_q <= 2'b01;
                            state_q      <= RSP;
                        end
                        t_ack: begin
                            cyc_q        <= 1'b0;
                            stb_q        <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            rsp_dat_q    <= we_q ? 32'd0 : wb_dat_i;
                            rsp_status_q <= 2'b00;
                            state_q      <= RSP;
                        end
                        t_rty: begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            if (retry_q < MR) begin
                                retry_q <= retry_q + 4'd1;
                                state_q <= BACKOFF;
                            end else begin
                                rsp_valid_q  <= 1'b1;
                                rsp_dat_q    <= '0;
                                rsp_status_q <= 2'b11;
                                state_q      <= RSP;
                            end
                        end
                        expired: begin
                            cyc_q        <= 1'b0;
                            stb_q        <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            rsp_dat_q    <= '0;
                            rsp_status_q <= 2'b10;
                            state_q      <= RSP;
                        end
                        default: ;
                    endcase
                end
                BACKOFF: begin
                    tmo_q   <= '0;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    state_q <= REQ;
                end
                RSP: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = rdy_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = stb_q;
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_sel_o     = sel_q;
    assign wb_dat_o     = dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Randomized bench for wb_initiator with a transaction-level outcome model.
// Drives a scripted Wishbone slave and checks timing, status and bus fields.
module tb_wb_initiator;

    localparam int AW = 32;
    localparam int TO = 8;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [31:0]   cmd_dat = '0;
    logic [3:0]    cmd_sel = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_dat;
    logic [1:0]    rsp_status;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-3:0] wb_adr;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_dat_o;
    logic          wb_ack = 1'b0, wb_err = 1'b0;
    logic          wb_rty = 1'b0, wb_stall = 1'b0;
    logic [31:0]   wb_dat_i = '0;

    wb_initiator #(.AW(AW), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
        .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat),
        .rsp_status_o(rsp_status),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
        .wb_adr_o(wb_adr), .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty),
        .wb_stall_i(wb_stall), .wb_dat_i(wb_dat_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-attempt slave script: stall cycles, delay after acceptance,
    // termination {err,ack,rty} (0 = never), read data.
    int          sc_s[4];
    int          sc_d[4];
    logic [2:0]  sc_t[4];
    logic [31:0] sc_dat[4];

    task automatic set1(input int i, input int s, input int d,
                        input logic [2:0] t, input logic [31:0] dv);
        sc_s[i] = s; sc_d[i] = d; sc_t[i] = t; sc_dat[i] = dv;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic noise;
        wb_stall = 1'($urandom);
        {wb_err, wb_ack, wb_rty} = 3'($urandom);
        wb_dat_i = $urandom;
    endtask

    // Outcome of a whole command from the script, attempt by attempt.
    task automatic model(input logic we, output int lat,
                         output logic [1:0] st, output logic [31:0] rd,
                         output int att, output int ncyc, output int nstb);
        int eff, l;
        lat = 0; ncyc = 0; nstb = 0; att = 0; st = 0; rd = 0;
        for (int i = 0; i <= MR; i++) begin
            att = i + 1;
            eff = sc_s[i] + 1 + sc_d[i];
            l = (sc_t[i] != 0 && eff <= TO) ? eff : TO;
            ncyc += l;
            nstb += (sc_s[i] + 1 < l) ? sc_s[i] + 1 : l;
            lat += l + ((i > 0) ? 1 : 0);
            if (sc_t[i] == 0 || eff > TO) begin st = 2; break; end
            if (sc_t[i][2]) begin st = 1; break; end
            if (sc_t[i][1]) begin
                st = 0;
                rd = we ? 32'd0 : sc_dat[i];
                break;
            end
            if (i == MR) begin st = 3; break; end
        end
        lat += 1;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        int m_lat, m_att, m_cyc, m_stb;
        logic [1:0] m_st;
        logic [31:0] m_rd;
        int t, att, k, idx, ncyc, nstb, bad, extra;
        logic got, prev;
        logic [1:0] g_st;
        logic [31:0] g_rd;
        model(we, m_lat, m_st, m_rd, m_att, m_cyc, m_stb);
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr;
        cmd_dat = dat; cmd_sel = sel;
        {wb_err, wb_ack, wb_rty} = 3'b000;
        step;
        cmd_valid = 1'b0; cmd_we = 1'($urandom);
        cmd_adr = $urandom; cmd_dat = $urandom;
        cmd_sel = 4'($urandom);
        t = 1; att = 0; k = 0; idx = 0; ncyc = 0; nstb = 0;
        bad = 0; got = 1'b0; prev = 1'b0; g_st = 0; g_rd = 0;
        while (!got && t <= 300) begin
            if (rsp_valid) begin
                got = 1'b1; g_st = rsp_status; g_rd = rsp_dat;
            end
            if (wb_cyc) begin
                if (!prev) begin
                    idx = (att > 3) ? 3 : att;
                    att++; k = 0;
                end
                ncyc++;
                if (wb_stb) nstb++;
                if (wb_adr !== adr[31:2] || wb_sel !== sel ||
                    wb_we !== we || wb_dat_o !== dat) bad++;
                wb_dat_i = $urandom;
                {wb_err, wb_ack, wb_rty} = 3'b000;
                if (k < sc_s[idx]) begin
                    wb_stall = 1'b1;
                    {wb_err, wb_ack, wb_rty} = 3'($urandom);
                end else begin
                    wb_stall = (k == sc_s[idx]) ? 1'b0 : 1'($urandom);
                    if (k == sc_s[idx] + sc_d[idx]) begin
                        {wb_err, wb_ack, wb_rty} = sc_t[idx];
                        wb_dat_i = sc_dat[idx];
                    end
                end
                k++;
            end else begin
                noise;
            end
            prev = wb_cyc;
            if (!got) begin step; t++; end
        end
        chk("rsp_seen", 32'(got), 32'd1);
        chk("latency", 32'(t), 32'(m_lat));
        chk("status", 32'(g_st), 32'(m_st));
        chk("rdata", g_rd, m_rd);
        chk("attempts", 32'(att), 32'(m_att));
        chk("cyc_cycles", 32'(ncyc), 32'(m_cyc));
        chk("stb_cycles", 32'(nstb), 32'(m_stb));
        chk("field_stable", 32'(bad), 32'd0);
        noise;
        step;
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("ready_after", 32'(cmd_ready), 32'd1);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            noise; wb_ack = 1'b1;
            step;
            if (rsp_valid) extra++;
        end
        chk("late_term_ign", 32'(extra), 32'd0);
        chk("rsp_hold", rsp_dat, m_rd);
    endtask

    initial begin
        int extra;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_stb", 32'(wb_stb), 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        chk("rst_rdat", rsp_dat, 32'd0);
        chk("rst_stat", 32'(rsp_status), 32'd0);
        chk("rst_adr", 32'(wb_adr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step;

        set1(0, 0, 0, 3'b010, 32'hDEADBEEF);
        run_txn(1'b0, 32'h0000_0010, $urandom, 4'hF);
        set1(0, 3, 2, 3'b010, $urandom);
        run_txn(1'b1, 32'h1234_5678, 32'hA5A5_0F0F, 4'h3);
        set1(0, 0, 1, 3'b001, 0); set1(1, 1, 0, 3'b001, 0);
        set1(2, 0, 0, 3'b001, 0); set1(3, 2, 1, 3'b001, 0);
        run_txn(1'b0, 32'h0000_0100, $urandom, 4'hC);
        set1(0, 1, 0, 3'b000, 0);
        run_txn(1'b0, 32'h0000_0200, $urandom, 4'h1);
        set1(0, 0, 2, 3'b110, 32'h1111_2222);
        run_txn(1'b0, 32'h0000_0300, $urandom, 4'hF);
        set1(0, 3, 4, 3'b010, 32'hCAFE_F00D);
        run_txn(1'b0, 32'h0000_0400, $urandom, 4'hF);
        set1(0, 4, 4, 3'b010, 32'h5555_AAAA);
        run_txn(1'b0, 32'h0000_0500, $urandom, 4'hF);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++)
                set1(i, $urandom_range(0, 4), $urandom_range(0, 4),
                     3'($urandom), $urandom);
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom));
        end

        set1(0, 0, 0, 3'b000, 0);
        cmd_valid = 1'b1; cmd_we = 1'b0;
        cmd_adr = 32'h40; cmd_sel = 4'hF;
        {wb_err, wb_ack, wb_rty, wb_stall} = 4'b0000;
        step;
        cmd_valid = 1'b0;
        step;
        step;
        chk("wait_cyc", 32'(wb_cyc), 32'd1);
        chk("wait_stb", 32'(wb_stb), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cyc", 32'(wb_cyc), 32'd0);
        chk("async_stb", 32'(wb_stb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            noise; wb_ack = 1'b1;
            step;
            if (rsp_valid) extra++;
        end
        chk("rst_no_rsp", 32'(extra), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_stat2", 32'(rsp_status), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter AW, default 32, SHALL set the Wishbone byte-address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles an attempt may spend with wb_cyc_o high; range 1..65535.
REQ-003 Parameter MAX_RETRY, default 3, SHALL set the number of reissues allowed after wb_rty_i; range 0..15.
REQ-004 Ports SHALL be:
 clk_i  in  1  sole clock, rising edge
 rst_n_i  in  1  asynchronous, active-low reset
 cmd_valid_i  in  1  command present
 cmd_ready_o  out  1  command accepted when high with cmd_valid_i
 cmd_we_i  in  1  1=write, 0=read
 cmd_adr_i  in  AW  byte address
 cmd_dat_i  in  32  write data
 cmd_sel_i  in  4  byte lanes
 rsp_valid_o  out  1  one-cycle response strobe
 rsp_dat_o  out  32  read data
 rsp_status_o  out  2  00 ok, 01 err, 10 timeout, 11 retry exhausted
 wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone B4 pipelined master controls
 wb_adr_o  out  AW-2  word address (cmd_adr_i[AW-1:2])
 wb_sel_o  out  4;  wb_dat_o  out  32
 wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1
 wb_dat_i  in  32  read data

Function
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT, BACKOFF and RSP; one transaction outstanding at most.
REQ-006 cmd_ready_o SHALL be high only in IDLE; on cmd_valid_i&cmd_ready_o, all cmd_* fields SHALL be registered and the FSM SHALL enter REQ.
REQ-007 In REQ, wb_cyc_o=wb_stb_o=1; stay in REQ while wb_stall_i=1; wb_adr_o/wb_sel_o/wb_we_o/wb_dat_o SHALL remain stable from REQ entry until wb_cyc_o falls.
REQ-008 On a REQ cycle with wb_stall_i=0, the request SHALL be considered accepted; wb_stb_o SHALL be 0 from the next cycle (WAIT) with wb_cyc_o held 1.
REQ-009 Termination (ack/err/rty) SHALL be sampled only while wb_cyc_o=1 and after or in the same cycle as acceptance; a termination in the acceptance cycle SHALL be honoured; terminations while wb_stall_i=1 in REQ SHALL be ignored.
REQ-010 Simultaneous terminations SHALL be prioritised err > ack > rty.
REQ-011 On ack, the FSM SHALL enter RSP with status 00; rsp_dat_o SHALL capture wb_dat_i for reads and 0 for writes.
REQ-012 On err, the FSM SHALL enter RSP with status 01 and rsp_dat_o=0.
REQ-013 On rty with retry count < MAX_RETRY, the count SHALL increment and the FSM SHALL enter BACKOFF (wb_cyc_o=0 for exactly one cycle), then REQ with identical bus fields; otherwise RSP with status 11.
REQ-014 A 16-bit timeout counter SHALL clear on REQ entry (including reissues) and increment each cycle in REQ/WAIT; when it reaches TIMEOUT with no termination that cycle, the FSM SHALL enter RSP with status 10; a termination in that same cycle SHALL take precedence.
REQ-015 In RSP, wb_cyc_o=wb_stb_o=0, rsp_valid_o=1 for exactly one cycle, then IDLE; rsp_dat_o/rsp_status_o SHALL hold until the next response.
REQ-016 Terminations arriving while wb_cyc_o=0 (late acks after timeout/retry) SHALL be ignored.
REQ-017 Minimum latency: command accepted at edge N -> stb high in cycle N+1; ack in N+1 -> rsp_valid_o in N+2 -> cmd_ready_o in N+3.
REQ-018 The retry count SHALL clear on every command acceptance.

Reset
REQ-019 While rst_n_i=0, asynchronously: FSM=IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o/wb_sel_o/wb_dat_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_status_o=00, counters=0; cmd_ready_o SHALL be 1 after release.
REQ-020 Reset mid-transaction SHALL abort it with no response generated; the bus cycle SHALL drop immediately.

Verification
REQ-021 Read 0x0000_0010, no stall, ack+wb_dat_i=0xDEADBEEF in first stb cycle -> wb_adr_o=0x4, rsp_valid_o in N+2, rsp_dat_o=0xDEADBEEF, status 00.
REQ-022 Write with wb_stall_i high 3 cycles, ack 2 cycles after acceptance -> stb high exactly 4 cycles, fields stable, status 00, rsp_dat_o=0.
REQ-023 rty on every attempt, MAX_RETRY=3 -> 4 bus cycles separated by one-cycle cyc gaps, status 11.
REQ-024 TIMEOUT=8, slave never acks -> rsp status 10 when counter reaches 8; ack injected 2 cycles later ignored, no second rsp_valid_o.
REQ-025 ack and err in same cycle -> status 01; rst_n_i pulsed during WAIT -> cyc drops asynchronously, no rsp_valid_o, cmd_ready_o=1 after release.
